// File: rtl/layer1_mac_counter_act.sv
// MAC-completion counter with sticky ack_mac plus a combinational ReLU activation.
// Define LEAKY_RELU_EN to turn negative pre-activations into z_value >>> 3 instead of zero.
module layer1_mac_counter_act #(
   parameter int N_INPUTS = 2,
   parameter int DATA_W   = 8,
   parameter int CNT_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ack,
   output logic                     ack_mac,
   output logic [CNT_W-1:0]         count,
   input  logic signed [DATA_W-1:0] z_value,
   output logic signed [DATA_W-1:0] a
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N_INPUTS - 1);

   logic z_negative;
   logic z_zero;

   // Once ack_mac is set the counter freezes at N_INPUTS until the next reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= '0;
         ack_mac <= 1'b0;
      end else if (ack && !ack_mac) begin
         count <= count + 1'b1;
         if (count == LAST_COUNT) begin
            ack_mac <= 1'b1;
         end
      end
   end

   assign z_negative = z_value[DATA_W-1];
   assign z_zero     = (z_value == '0);

   always_comb begin
      a = '0;
      if (!z_negative && !z_zero) begin
         a = z_value;
      end
`ifdef LEAKY_RELU_EN
      else if (z_negative) begin
         a = z_value >>> 3;
      end
`endif
   end

endmodule

// File: tb/tb_layer1_mac_counter_act.sv
// Self-checking bench for layer1_mac_counter_act: directed scenarios plus randomized
// ack/reset/z_value traffic compared every cycle against a saturating-count model.
module tb_layer1_mac_counter_act;

   localparam int N_INPUTS = 2;
   localparam int DATA_W   = 8;
   localparam int CNT_W    = 2;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     ack = 1'b0;
   logic                     ack_mac;
   logic [CNT_W-1:0]         count;
   logic signed [DATA_W-1:0] z_value = '0;
   logic signed [DATA_W-1:0] a;

   int n_cmp  = 0;
   int n_fail = 0;
   int acks_seen = 0;
   bit checking = 1'b0;

   layer1_mac_counter_act #(
      .N_INPUTS(N_INPUTS),
      .DATA_W  (DATA_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .ack    (ack),
      .ack_mac(ack_mac),
      .count  (count),
      .z_value(z_value),
      .a      (a)
   );

   always #5 clk = ~clk;

   // Reference: acks accepted since the last reset, saturating at N_INPUTS.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         acks_seen <= 0;
      end else if (ack && acks_seen < N_INPUTS) begin
         acks_seen <= acks_seen + 1;
      end
   end

   function automatic int model_act(int z);
      if (z > 0) return z;
`ifdef LEAKY_RELU_EN
      return -((-z + 7) / 8);
`else
      return 0;
`endif
   endfunction

   task automatic check_output(string name, int actual, int expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic apply_stimulus(bit ack_v, bit rst_v, int z_v);
      @(posedge clk);
      #2;
      ack     = ack_v;
      rst     = rst_v;
      z_value = DATA_W'(z_v);
   endtask

   always @(negedge clk) begin
      if (checking) begin
         check_output("cyc_count", int'(count), (acks_seen < N_INPUTS) ? acks_seen : N_INPUTS);
         check_output("cyc_ack_mac", int'(ack_mac), (acks_seen >= N_INPUTS) ? 1 : 0);
         check_output("cyc_act", int'(a), model_act(int'(z_value)));
      end
   end

   int sweep_z   [7] = '{20, 1, 0, -1, -2, -128, 127};
`ifdef LEAKY_RELU_EN
   int sweep_exp [7] = '{20, 1, 0, -1, -1, -16, 127};
`else
   int sweep_exp [7] = '{20, 1, 0, 0, 0, 0, 127};
`endif

   initial begin
      int z_calc;
      #1 rst = 1'b0;
      checking = 1'b1;

      // Reset held while ack toggles.
      for (int i = 0; i < 5; i++) apply_stimulus(i[0], 1'b0, 0);
      #1;
      check_output("rst_count", int'(count), 0);
      check_output("rst_ack_mac", int'(ack_mac), 0);
      apply_stimulus(1'b0, 1'b1, 0);
      apply_stimulus(1'b0, 1'b1, 0);
      #1;
      check_output("release_count", int'(count), 0);

      // Two pulses separated by idle cycles.
      apply_stimulus(1'b1, 1'b1, 0);
      apply_stimulus(1'b0, 1'b1, 0);
      #1;
      check_output("first_ack_count", int'(count), 1);
      check_output("first_ack_mac", int'(ack_mac), 0);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 0);
      apply_stimulus(1'b1, 1'b1, 0);
      apply_stimulus(1'b0, 1'b1, 0);
      #1;
      check_output("second_ack_count", int'(count), 2);
      check_output("second_ack_mac", int'(ack_mac), 1);
      for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1, 0);
      #1;
      check_output("sticky_ack_mac", int'(ack_mac), 1);

      // Back-to-back acks saturate at N_INPUTS.
      apply_stimulus(1'b0, 1'b0, 0);
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 0);
      apply_stimulus(1'b0, 1'b1, 0);
      #1;
      check_output("b2b_count", int'(count), 2);
      check_output("b2b_ack_mac", int'(ack_mac), 1);

      // Asynchronous reset mid-count, then a fresh evaluation.
      apply_stimulus(1'b0, 1'b0, 0);
      apply_stimulus(1'b1, 1'b1, 0);
      apply_stimulus(1'b0, 1'b1, 0);
      #1;
      check_output("mid_count", int'(count), 1);
      rst = 1'b0;
      #1;
      check_output("async_count", int'(count), 0);
      check_output("async_ack_mac", int'(ack_mac), 0);
      apply_stimulus(1'b1, 1'b1, 0);
      apply_stimulus(1'b0, 1'b1, 0);
      #1;
      check_output("rerun1_ack_mac", int'(ack_mac), 0);
      apply_stimulus(1'b1, 1'b1, 0);
      apply_stimulus(1'b0, 1'b1, 0);
      #1;
      check_output("rerun2_ack_mac", int'(ack_mac), 1);

      // Activation sweep, including with rst asserted.
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(1'b0, i[0], sweep_z[i]);
         #1;
         check_output("sweep_act", int'(a), sweep_exp[i]);
      end

      // Neuron example in Q3.4: weights 20,13 with inputs 16,16 and bias -2.
      z_calc = ((20 * 16 + 13 * 16) >>> 4) - 2;
      apply_stimulus(1'b0, 1'b1, z_calc);
      #1;
      check_output("neuron_pos", int'(a), 31);
      z_calc = ((20 * -16 + 13 * -16) >>> 4) - 2;
      apply_stimulus(1'b0, 1'b1, z_calc);
      #1;
`ifdef LEAKY_RELU_EN
      check_output("neuron_neg", int'(a), -5);
`else
      check_output("neuron_neg", int'(a), 0);
`endif

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         apply_stimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 39) != 0),
                        int'($signed(8'($urandom))));
      end
      apply_stimulus(1'b0, 1'b1, 0);
      @(posedge clk);
      #2;
      checking = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/layer1_mac_counter_act.md
Name: layer1_mac_counter_act

Overview:
- Control and activation helper for a single fully-connected neuron layer.
- A sticky counter counts MAC-completion pulses. Once all N_INPUTS products are accumulated, it raises ack_mac, which gates further MAC requests and starts the bias-add stage.
- A zero-latency combinational activation maps the biased pre-activation z_value to the neuron output a.
- Data is signed fixed point with 4 fractional bits (Q3.4 at 8 bits).

Parameters:
- N_INPUTS, 2, number of MAC accumulate steps per neuron evaluation (must be >= 1).
- DATA_W, 8, width of z_value and a (signed two's complement).
- CNT_W, 2, width of count; must satisfy 2^CNT_W > N_INPUTS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately; rst=1 runs).
- ack  input  1  one-cycle pulse from the MAC datapath: one product was accumulated.
- ack_mac  output  1  registered; high once N_INPUTS ack pulses are counted; stays high until reset.
- count  output  CNT_W  registered number of ack pulses accepted so far (0..N_INPUTS).
- z_value  input  DATA_W  signed pre-activation value (accumulator plus bias).
- a  output  DATA_W  signed activation result, combinational from z_value.

Behaviour:
- Reset: while rst=0, count=0 and ack_mac=0 asynchronously, regardless of clk. Release is sampled on the next rising edge.
- Counting, on each rising edge with rst=1:
  - If ack=1 and ack_mac=0: count <= count+1.
  - If additionally count == N_INPUTS-1: ack_mac <= 1 in the same edge.
  - If ack=0: count and ack_mac hold.
- Latency: ack_mac rises on the same edge that registers the N_INPUTS-th ack, so it is visible one cycle after that ack is sampled high.
- Saturation:
  - When ack_mac=1, further ack pulses are ignored.
  - count holds at N_INPUTS; there is no wrap-around.
  - ack_mac stays 1 until rst=0.
  - The upstream MAC request is formed as req & ~ack_mac, so the sticky ack_mac is what stops the MAC.
- Back-to-back ack pulses on consecutive cycles are each counted; there is no minimum gap.
- Reset mid-count: asserting rst at any time clears count and ack_mac immediately. A partially counted evaluation is discarded.
- Simultaneous ack=1 and a rst=0 edge: reset wins.
- Activation (default ReLU), purely combinational, no clock involvement:
  - a = z_value when z_value > 0; otherwise a = 0.
  - z_value = 0 gives a = 0; the most negative value (-128 at 8 bits) gives 0; +127 passes unchanged.
- The activation output is independent of rst and of the counter state.
- No X propagation from internal state: every register has a defined reset value.

Optional Feature:
- Macro LEAKY_RELU_EN.
- When defined: for z_value < 0, a = z_value >>> 3 (arithmetic shift, sign preserved, rounds toward -inf). Examples: -8 gives -1, -1 gives -1, -128 gives -16. Positive and zero inputs are unchanged from ReLU.
- When undefined: plain ReLU as specified in Behaviour. The counter is identical in both builds.

Test Plan:
- Reset: hold rst=0 with ack toggling -> count=0, ack_mac=0 throughout. Release rst with ack=0 -> both hold at 0.
- Two ack pulses (N_INPUTS=2) separated by 3 idle cycles -> count goes 1 then 2; ack_mac=1 one cycle after the second ack is sampled. With ack low afterwards, ack_mac remains 1 for at least 10 cycles.
- Back-to-back ack for 4 cycles -> count reaches 2 and stays 2; ack_mac=1 from cycle 2; extra pulses ignored.
- Async reset mid-count: after 1 ack, drop rst between clock edges -> count and ack_mac go to 0 immediately, without a clock edge. A re-run then needs 2 fresh acks.
- ReLU sweep over z_value = 20, 1, 0, -1, -2, -128, 127 -> a = 20, 1, 0, 0, 0, 0, 127. With LEAKY_RELU_EN: -2 gives -1, -16 gives -2, -128 gives -16.
- Neuron example: weights 20 and 13, inputs 16 and 16 give accumulator 33; with bias -2, z_value=31 -> a=31. With inputs -16 and -16, z_value=-35 -> a=0 (leaky build: -5).
